mk_pack_writer: RTL and testbench
=================================

MK_PACK_WRITER -- requirements
Module: mk_pack_writer

Interface
REQ-001 SHALL have parameter NUM_PEGS, default 8, number of PE groups (max words per segment).
REQ-002 SHALL have parameter LOG2_PEGS, default 3, width of vn field.
REQ-003 SHALL have parameter NUM_PES, default 8, lanes per FIFO word.
REQ-004 SHALL have parameter LOG2_PES, default 3, width of dest field.
REQ-005 SHALL have parameter DATA_TYPE, default 8, element width.
REQ-006 SHALL have port clk  input  1  single clock; all state rising-edge.
REQ-007 SHALL have port rst  input  1  reset, asynchronous, active-low.
REQ-008 SHALL have port i_elem_valid  input  1  element offered.
REQ-009 SHALL have port o_elem_ready  output  1  element accepted when valid&ready.
REQ-010 SHALL have port i_elem_data  input  DATA_TYPE  nonzero value.
REQ-011 SHALL have port i_elem_col  input  LOG2_PES  destination PE index.
REQ-012 SHALL have port i_elem_row_last  input  1  last element of a matrix row.
REQ-013 SHALL have port i_elem_seg_last  input  1  last element of a segment (implies row_last).
REQ-014 SHALL have port i_elem_blk_last  input  1  last element of block row (valid only with seg_last).
REQ-015 SHALL have port i_fifo_MK_full  input  1  downstream FIFO full.
REQ-016 SHALL have port o_fifo_wr_en  output  1  FIFO write strobe.
REQ-017 SHALL have port o_fifo_MK_data_in  output  DATA_TYPE*NUM_PES  lane data, lane 0 in LSBs.
REQ-018 SHALL have port o_fifo_dest_in  output  LOG2_PES*NUM_PES  lane dest.
REQ-019 SHALL have port o_fifo_vn_in  output  LOG2_PEGS*NUM_PES  lane vn.
REQ-020 SHALL have port o_fifo_flag_in  output  2  word flag.
REQ-021 SHALL have port o_seg_overflow  output  1  sticky: segment exceeded NUM_PEGS words.

Function
REQ-022 SHALL accept an element iff i_elem_valid & o_elem_ready; o_elem_ready = !(out_valid & i_fifo_MK_full), where out_valid is the staged-word register flag.
REQ-023 SHALL write each accepted element into assembly lane lane_cnt (data, col as dest, vn_cnt as vn), then lane_cnt++.
REQ-024 SHALL close the word when lane_cnt==NUM_PES-1 on acceptance, or on seg_last; closing copies the assembly word plus flag into the staging register (out_valid=1) the same edge and clears assembly lanes and lane_cnt to 0.
REQ-025 SHALL zero data, dest and vn of unfilled lanes in a closed word.
REQ-026 SHALL set flag: 11 if closing element has blk_last; 10 if seg_last only; 00 if word full at row_last; 01 if word full mid-row.
REQ-027 SHALL treat seg_last as row_last, and blk_last without seg_last as ignored.
REQ-028 SHALL increment vn_cnt (mod NUM_PEGS) on accepted row_last without seg_last; SHALL clear vn_cnt to 0 on accepted seg_last.
REQ-029 SHALL drive o_fifo_wr_en = out_valid & !i_fifo_MK_full combinationally; out_valid clears on write unless a new word closes that same cycle (then it reloads, stays 1).
REQ-030 SHALL hold staged outputs stable while out_valid & i_fifo_MK_full.
REQ-031 SHALL keep a per-segment word counter (LOG2_PEGS+1 bits), incremented per closed word, cleared on seg_last close; closing a word with counter==NUM_PEGS SHALL set o_seg_overflow, which clears only on reset.
REQ-032 Latency: word-closing element accepted at edge t -> o_fifo_wr_en high in cycle after t if not full; sustained throughput one element per cycle.

Reset
REQ-033 On rst low, asynchronously: out_valid, lane_cnt, vn_cnt, word counter, o_seg_overflow, all staged/assembly fields and flag SHALL be 0; o_fifo_wr_en=0, o_elem_ready=1.
REQ-034 A partial word in progress at reset SHALL be discarded; first post-reset element goes to lane 0, vn 0.

Verification
REQ-035 8 elements, one row, seg_last on 8th, cols 0..7 -> one write, flag 10, vn all 0, dest 0..7.
REQ-036 one row of 10 elements, seg_last on 10th -> write 1 flag 01 full; write 2 lanes 0-1 data, lanes 2-7 zero, flag 10.
REQ-037 rows of 3 and 5 elements, second ends seg_last+blk_last -> one write flag 11, vn lanes 0,0,0,1,1,1,1,1.
REQ-038 full held high with staged word and next word closing -> ready low, wr_en low, outputs stable; full released -> one write per cycle, both words in order.
REQ-039 rst low after 5 elements -> all outputs 0; next 8-element seg word has lane 0 = first post-reset element, vn 0.
REQ-040 one segment of 9 full words (72 elements) -> o_seg_overflow rises at 9th close, stays 1 until reset.

Source files
------------

// File: rtl/mk_pack_writer_if.sv
// Element-stream and FIFO-write signals of the pack writer, bundled as one interface.
// master is the writer's view; slave is the element producer / FIFO side.
interface mk_pack_writer_if #(
    parameter int LOG2_PEGS = 3,
    parameter int NUM_PES   = 8,
    parameter int LOG2_PES  = 3,
    parameter int DATA_TYPE = 8
);
    logic                           i_elem_valid;
    logic                           o_elem_ready;
    logic [DATA_TYPE-1:0]           i_elem_data;
    logic [LOG2_PES-1:0]            i_elem_col;
    logic                           i_elem_row_last;
    logic                           i_elem_seg_last;
    logic                           i_elem_blk_last;
    logic                           i_fifo_MK_full;
    logic                           o_fifo_wr_en;
    logic [DATA_TYPE*NUM_PES-1:0]   o_fifo_MK_data_in;
    logic [LOG2_PES*NUM_PES-1:0]    o_fifo_dest_in;
    logic [LOG2_PEGS*NUM_PES-1:0]   o_fifo_vn_in;
    logic [1:0]                     o_fifo_flag_in;

    modport master (
        input  i_elem_valid, i_elem_data, i_elem_col,
        input  i_elem_row_last, i_elem_seg_last, i_elem_blk_last,
        input  i_fifo_MK_full,
        output o_elem_ready, o_fifo_wr_en,
        output o_fifo_MK_data_in, o_fifo_dest_in, o_fifo_vn_in, o_fifo_flag_in
    );

    modport slave (
        output i_elem_valid, i_elem_data, i_elem_col,
        output i_elem_row_last, i_elem_seg_last, i_elem_blk_last,
        output i_fifo_MK_full,
        input  o_elem_ready, o_fifo_wr_en,
        input  o_fifo_MK_data_in, o_fifo_dest_in, o_fifo_vn_in, o_fifo_flag_in
    );
endinterface

// File: rtl/mk_pack_writer.sv
// Packs a stream of sparse elements into NUM_PES-lane FIFO words, one word per
// segment chunk, with per-lane dest/vn tags, a word flag and a one-word staging register.
module mk_pack_writer #(
    parameter int NUM_PEGS  = 8,
    parameter int LOG2_PEGS = 3,
    parameter int NUM_PES   = 8,
    parameter int LOG2_PES  = 3,
    parameter int DATA_TYPE = 8
) (
    input  logic                clk,
    input  logic                rst,
    mk_pack_writer_if.master    bus,
    output logic                o_seg_overflow
);
    localparam int DW    = DATA_TYPE * NUM_PES;
    localparam int TW    = LOG2_PES * NUM_PES;
    localparam int VW    = LOG2_PEGS * NUM_PES;
    localparam int CNT_W = LOG2_PEGS + 1;

    // Handshake: an element moves when i_elem_valid & o_elem_ready at a rising
    // edge; a staged word moves when o_fifo_wr_en is high at a rising edge.
    logic                   out_valid;
    logic [LOG2_PES-1:0]    lane_cnt;
    logic [LOG2_PEGS-1:0]   vn_cnt;
    logic [CNT_W-1:0]       word_cnt;

    logic [DATA_TYPE-1:0]   asm_data [NUM_PES];
    logic [LOG2_PES-1:0]    asm_dest [NUM_PES];
    logic [LOG2_PEGS-1:0]   asm_vn   [NUM_PES];

    logic [DW-1:0]          stg_data;
    logic [TW-1:0]          stg_dest;
    logic [VW-1:0]          stg_vn;
    logic [1:0]             stg_flag;

    logic                   accept;
    logic                   seg_end;
    logic                   row_end;
    logic                   blk_end;
    logic                   word_full;
    logic                   close;
    logic [1:0]             close_flag;
    logic [DW-1:0]          nxt_data;
    logic [TW-1:0]          nxt_dest;
    logic [VW-1:0]          nxt_vn;

    assign bus.o_elem_ready = !(out_valid && bus.i_fifo_MK_full);
    assign bus.o_fifo_wr_en = out_valid && !bus.i_fifo_MK_full;

    assign accept    = bus.i_elem_valid && bus.o_elem_ready;
    assign seg_end   = bus.i_elem_seg_last;
    assign row_end   = bus.i_elem_row_last || bus.i_elem_seg_last;
    assign blk_end   = bus.i_elem_seg_last && bus.i_elem_blk_last;
    assign word_full = (lane_cnt == LOG2_PES'(NUM_PES - 1));
    assign close     = accept && (word_full || seg_end);

    // Word as it would look with the offered element dropped into its lane;
    // lanes above lane_cnt are still zero from the previous clear.
    always_comb begin
        nxt_data = '0;
        nxt_dest = '0;
        nxt_vn   = '0;
        for (int i = 0; i < NUM_PES; i++) begin
            if (lane_cnt == LOG2_PES'(i)) begin
                nxt_data[i*DATA_TYPE +: DATA_TYPE] = bus.i_elem_data;
                nxt_dest[i*LOG2_PES  +: LOG2_PES]  = bus.i_elem_col;
                nxt_vn[i*LOG2_PEGS   +: LOG2_PEGS] = vn_cnt;
            end else begin
                nxt_data[i*DATA_TYPE +: DATA_TYPE] = asm_data[i];
                nxt_dest[i*LOG2_PES  +: LOG2_PES]  = asm_dest[i];
                nxt_vn[i*LOG2_PEGS   +: LOG2_PEGS] = asm_vn[i];
            end
        end
    end

    always_comb begin
        close_flag = 2'b01;
        if (blk_end)
            close_flag = 2'b11;
        else if (seg_end)
            close_flag = 2'b10;
        else if (row_end)
            close_flag = 2'b00;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            out_valid      <= 1'b0;
            lane_cnt       <= '0;
            vn_cnt         <= '0;
            word_cnt       <= '0;
            o_seg_overflow <= 1'b0;
            stg_data       <= '0;
            stg_dest       <= '0;
            stg_vn         <= '0;
            stg_flag       <= 2'b00;
            for (int i = 0; i < NUM_PES; i++) begin
                asm_data[i] <= '0;
                asm_dest[i] <= '0;
                asm_vn[i]   <= '0;
            end
        end else begin
            if (accept) begin
                if (close) begin
                    lane_cnt <= '0;
                    for (int i = 0; i < NUM_PES; i++) begin
                        asm_data[i] <= '0;
                        asm_dest[i] <= '0;
                        asm_vn[i]   <= '0;
                    end
                end else begin
                    lane_cnt           <= lane_cnt + 1'b1;
                    asm_data[lane_cnt] <= bus.i_elem_data;
                    asm_dest[lane_cnt] <= bus.i_elem_col;
                    asm_vn[lane_cnt]   <= vn_cnt;
                end

                if (seg_end)
                    vn_cnt <= '0;
                else if (bus.i_elem_row_last)
                    vn_cnt <= (vn_cnt == LOG2_PEGS'(NUM_PEGS - 1)) ? '0 : vn_cnt + 1'b1;
            end

            // A closing word can only be accepted when the staging slot is free
            // or being written this same edge, so reloading never loses a word.
            if (close) begin
                out_valid <= 1'b1;
                stg_data  <= nxt_data;
                stg_dest  <= nxt_dest;
                stg_vn    <= nxt_vn;
                stg_flag  <= close_flag;
                word_cnt  <= seg_end ? '0 : word_cnt + 1'b1;
                if (word_cnt == CNT_W'(NUM_PEGS))
                    o_seg_overflow <= 1'b1;
            end else if (bus.o_fifo_wr_en) begin
                out_valid <= 1'b0;
            end
        end
    end

    assign bus.o_fifo_MK_data_in = stg_data;
    assign bus.o_fifo_dest_in    = stg_dest;
    assign bus.o_fifo_vn_in      = stg_vn;
    assign bus.o_fifo_flag_in    = stg_flag;
endmodule

// File: tb/tb_mk_pack_writer.sv
// Bench for mk_pack_writer: directed segments plus random ones, each segment turned into
// expected FIFO words by chunking its element list, compared word by word at the FIFO port.
module tb_mk_pack_writer;
    localparam int W = 114;   // {flag[2], vn[24], dest[24], data[64]}

    typedef struct {
        logic [7:0] d;
        logic [2:0] c;
        logic       rl;
        logic       sl;
        logic       bl;
    } elem_t;

    logic clk;
    logic rst_n;
    logic ovf;
    int   checks;
    int   errors;

    logic [W-1:0] exp_q[$];
    elem_t        seg_q[$];
    int           rows_q[$];
    logic         exp_ovf;
    logic [63:0]  held;
    bit           done;

    mk_pack_writer_if bus ();

    mk_pack_writer dut (
        .clk            (clk),
        .rst            (rst_n),
        .bus            (bus),
        .o_seg_overflow (ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Scoreboard: every FIFO write must match the oldest expected word.
    always @(negedge clk) begin
        #2;
        if (rst_n && bus.o_fifo_wr_en) begin
            checks++;
            assert (exp_q.size() !== 0) else begin
                errors++;
                $error("FAIL unexpected_write obs=%h exp=none",
                       {bus.o_fifo_flag_in, bus.o_fifo_vn_in, bus.o_fifo_dest_in, bus.o_fifo_MK_data_in});
            end
            if (exp_q.size() != 0) begin
                checks++;
                assert ({bus.o_fifo_flag_in, bus.o_fifo_vn_in, bus.o_fifo_dest_in, bus.o_fifo_MK_data_in} === exp_q[0]) else begin
                    errors++;
                    $error("FAIL fifo_word obs=%h exp=%h",
                           {bus.o_fifo_flag_in, bus.o_fifo_vn_in, bus.o_fifo_dest_in, bus.o_fifo_MK_data_in}, exp_q[0]);
                end
                void'(exp_q.pop_front());
            end
        end
    end

    // Builds seg_q from rows_q and predicts its words: the segment is cut into
    // NUM_PES-element chunks, vn is the row number within the segment.
    task automatic gen_seg(input bit blk, input bit seq_cols);
        int idx;
        int ridx[$];
        int r;
        int nwords;
        elem_t e;
        logic [W-1:0] w;
        seg_q.delete();
        idx = 0;
        for (int i = 0; i < rows_q.size(); i++) begin
            for (int k = 0; k < rows_q[i]; k++) begin
                e.d  = 8'($urandom_range(1, 255));
                e.c  = seq_cols ? 3'(idx % 8) : 3'($urandom_range(0, 7));
                e.rl = (k == rows_q[i] - 1);
                e.sl = e.rl && (i == rows_q.size() - 1);
                e.bl = e.sl ? blk : ($urandom_range(0, 3) == 0);
                seg_q.push_back(e);
                ridx.push_back(i);
                idx++;
            end
        end
        nwords = 0;
        for (int s = 0; s < seg_q.size(); s += 8) begin
            int last;
            last = (s + 8 < seg_q.size()) ? s + 7 : seg_q.size() - 1;
            w = '0;
            for (int k = s; k <= last; k++) begin
                w[(k-s)*8 +: 8]      = seg_q[k].d;
                w[64 + (k-s)*3 +: 3] = seg_q[k].c;
                w[88 + (k-s)*3 +: 3] = 3'(ridx[k] % 8);
            end
            if (last == seg_q.size() - 1)
                w[113:112] = seg_q[last].bl ? 2'b11 : 2'b10;
            else
                w[113:112] = seg_q[last].rl ? 2'b00 : 2'b01;
            exp_q.push_back(w);
            nwords++;
        end
        r = nwords;
        if (r > 8)
            exp_ovf = 1'b1;
    endtask

    task automatic send(input elem_t e);
        int n;
        @(negedge clk);
        bus.i_elem_valid    = 1'b1;
        bus.i_elem_data     = e.d;
        bus.i_elem_col      = e.c;
        bus.i_elem_row_last = e.rl;
        bus.i_elem_seg_last = e.sl;
        bus.i_elem_blk_last = e.bl;
        #1;
        n = 0;
        while (!bus.o_elem_ready && n < 100) begin
            @(negedge clk);
            #1;
            n++;
        end
        checks++;
        assert (n < 100) else begin
            errors++;
            $error("FAIL ready_timeout obs=%0d exp=<100", n);
        end
        @(posedge clk);
    endtask

    task automatic idle();
        @(negedge clk);
        bus.i_elem_valid    = 1'b0;
        bus.i_elem_row_last = 1'b0;
        bus.i_elem_seg_last = 1'b0;
        bus.i_elem_blk_last = 1'b0;
    endtask

    task automatic send_seg();
        for (int i = 0; i < seg_q.size(); i++)
            send(seg_q[i]);
        idle();
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 300) begin
            @(negedge clk);
            n++;
        end
        repeat (2) @(negedge clk);
        checks++;
        assert (exp_q.size() === 0) else begin
            errors++;
            $error("FAIL drain obs=%0d exp=0", exp_q.size());
        end
    endtask

    task automatic check_zero(input string tag);
        checks++;
        assert ({bus.o_fifo_wr_en, bus.o_elem_ready, ovf} === 3'b010) else begin
            errors++;
            $error("FAIL %s_ctl obs=%b exp=010", tag, {bus.o_fifo_wr_en, bus.o_elem_ready, ovf});
        end
        checks++;
        assert ({bus.o_fifo_flag_in, bus.o_fifo_vn_in, bus.o_fifo_dest_in, bus.o_fifo_MK_data_in} === '0) else begin
            errors++;
            $error("FAIL %s_word obs=%h exp=0", tag,
                   {bus.o_fifo_flag_in, bus.o_fifo_vn_in, bus.o_fifo_dest_in, bus.o_fifo_MK_data_in});
        end
    endtask

    initial begin
        elem_t e;
        checks  = 0;
        errors  = 0;
        exp_ovf = 1'b0;
        rst_n   = 1'b0;
        bus.i_elem_valid    = 1'b0;
        bus.i_elem_data     = '0;
        bus.i_elem_col      = '0;
        bus.i_elem_row_last = 1'b0;
        bus.i_elem_seg_last = 1'b0;
        bus.i_elem_blk_last = 1'b0;
        bus.i_fifo_MK_full  = 1'b0;
        repeat (3) @(negedge clk);
        #2;
        check_zero("reset");
        @(negedge clk);
        rst_n = 1'b1;

        // One full row closing on seg_last, sequential columns.
        rows_q = '{8};
        gen_seg(1'b0, 1'b1);
        send_seg();
        drain();

        // Ten-element row: one full mid-row word then a two-lane tail.
        rows_q = '{10};
        gen_seg(1'b0, 1'b0);
        send_seg();
        drain();

        // Rows of 3 and 5 ending the block row.
        rows_q = '{3, 5};
        gen_seg(1'b1, 1'b0);
        send_seg();
        drain();

        // Backpressure: stage word A under full, hold off word B, then release.
        @(negedge clk);
        bus.i_fifo_MK_full = 1'b1;
        rows_q = '{8};
        gen_seg(1'b0, 1'b0);
        send_seg();
        held = exp_q[0][63:0];
        rows_q = '{4, 4};
        gen_seg(1'b1, 1'b0);
        fork
            send_seg();
            begin
                repeat (4) begin
                    @(negedge clk);
                    #2;
                    checks++;
                    assert ({bus.o_fifo_wr_en, bus.o_elem_ready} === 2'b00) else begin
                        errors++;
                        $error("FAIL full_hold_ctl obs=%b exp=00", {bus.o_fifo_wr_en, bus.o_elem_ready});
                    end
                    checks++;
                    assert (bus.o_fifo_MK_data_in === held) else begin
                        errors++;
                        $error("FAIL full_hold_data obs=%h exp=%h", bus.o_fifo_MK_data_in, held);
                    end
                end
                @(negedge clk);
                bus.i_fifo_MK_full = 1'b0;
            end
        join
        drain();

        // Random segments with random downstream backpressure.
        for (int t = 0; t < 6; t++) begin
            rows_q.delete();
            repeat ($urandom_range(1, 4)) rows_q.push_back($urandom_range(1, 12));
            gen_seg(1'($urandom_range(0, 1)), 1'b0);
            done = 1'b0;
            fork
                begin
                    send_seg();
                    done = 1'b1;
                end
                begin
                    while (!done) begin
                        @(negedge clk);
                        bus.i_fifo_MK_full = ($urandom_range(0, 3) == 0);
                    end
                    bus.i_fifo_MK_full = 1'b0;
                end
            join
            drain();
        end
        checks++;
        assert (ovf === 1'b0) else begin
            errors++;
            $error("FAIL ovf_quiet obs=%b exp=0", ovf);
        end

        // Nine full words in one segment.
        rows_q = '{72};
        gen_seg(1'b0, 1'b0);
        send_seg();
        drain();
        checks++;
        assert (ovf === exp_ovf) else begin
            errors++;
            $error("FAIL ovf_set obs=%b exp=%b", ovf, exp_ovf);
        end
        rows_q = '{2, 3};
        gen_seg(1'b0, 1'b0);
        send_seg();
        drain();
        checks++;
        assert (ovf === 1'b1) else begin
            errors++;
            $error("FAIL ovf_sticky obs=%b exp=1", ovf);
        end

        // Reset in the middle of a word: the partial word vanishes.
        rows_q = '{9};
        gen_seg(1'b0, 1'b0);
        exp_q.delete();
        for (int i = 0; i < 5; i++) begin
            e = seg_q[i];
            e.rl = 1'b0;
            e.sl = 1'b0;
            e.bl = 1'b0;
            send(e);
        end
        idle();
        rst_n = 1'b0;
        #2;
        check_zero("mid_reset");
        @(negedge clk);
        rst_n = 1'b1;
        exp_ovf = 1'b0;
        rows_q = '{8};
        gen_seg(1'b0, 1'b1);
        send_seg();
        drain();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
